// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle of the seven-segment scanner: packed hex value and blank mask in,
// segment/select pins plus scan status out.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    // master = user logic supplying the number, slave = the scanner driving the pins
    modport master (
        output value, blank,
        input  seg, digit_sel, digit_idx, frame_tick
    );
    modport slave (
        input  value, blank,
        output seg, digit_sel, digit_idx, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed seven-segment driver: internal prescaler, dead-time anti-ghosting,
// frame-coherent shadow of value/blank. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 2,
    parameter int DIV_COUNT      = 1024,
    parameter int DEAD_CYCLES    = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    seven_seg_scanner_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int DW    = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(DIV_COUNT - 1);
    localparam logic [DW-1:0]         DEAD_INIT = DW'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    // Inactive levels double as the XOR masks that apply output polarity
    localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [DW-1:0]           r_dead;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_tick;

    logic [NUM_DIGITS-1:0]   w_lz;
    logic [NUM_DIGITS-1:0]   w_latch_blank;
    logic                    w_boundary;
    logic                    w_wrap;
    logic                    w_lit;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg_on;
    logic [NUM_DIGITS-1:0]   w_sel_on;

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; the run of zeros ends at the first non-zero nibble
    logic w_run;
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_run   = w_run & (bus.value[4*k +: 4] == 4'h0);
            w_lz[k] = w_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_latch_blank = bus.blank | w_lz;
    assign w_boundary    = (r_presc == PRESC_MAX);
    assign w_wrap        = w_boundary && (r_idx == IDX_MAX);

    assign w_lit    = (r_dead == '0);
    assign w_nib    = r_shadow[4*r_idx +: 4];
    assign w_seg_on = (w_lit && !r_shadow_blank[r_idx]) ? decode(w_nib) : 7'h00;
    assign w_sel_on = w_lit ? (SEL_ONE << r_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc        <= '0;
            r_idx          <= '0;
            r_dead         <= DEAD_INIT;
            r_shadow       <= bus.value;
            r_shadow_blank <= w_latch_blank;
            r_seg          <= SEG_OFF;
            r_sel          <= SEL_OFF;
            r_tick         <= 1'b0;
        end else begin
            r_presc <= w_boundary ? '0 : r_presc + PW'(1);
            if (w_boundary)
                r_dead <= DEAD_INIT;
            else if (r_dead != '0)
                r_dead <= r_dead - DW'(1);

            if (w_wrap)
                r_idx <= '0;
            else if (w_boundary)
                r_idx <= r_idx + IDX_W'(1);

            // Display data only moves at the frame wrap, so a frame never tears
            if (w_wrap) begin
                r_shadow       <= bus.value;
                r_shadow_blank <= w_latch_blank;
            end

            r_tick <= w_wrap;
            r_seg  <= w_seg_on ^ SEG_OFF;
            r_sel  <= w_sel_on ^ SEL_OFF;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_sel  = r_sel;
    assign bus.digit_idx  = r_idx;
    assign bus.frame_tick = r_tick;

endmodule
